uart_mm_tx: RTL and testbench
=============================

# uart_mm_tx

Memory-mapped UART transmitter: a bus master writes bytes into a small register map, the block buffers them in a FIFO and serialises them as 8N1 frames (LSB first, optional parity) on `tx`. It is the transmit-side counterpart of the team's UART receiver and uses the same bit period (`CLKS_PER_BIT` clocks per bit), so a `tx` → `frame` loopback must reproduce every byte.

## Interface
- `CLKS_PER_BIT`, 5: clocks per serial bit; ≥ 2.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥ 2.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: bus write strobe, one cycle per access.
- `rd_en` in 1: bus read strobe.
- `addr` in 2: register address.
- `wdata` in 8: write data.
- `rdata` out 8: read data, registered.
- `tx` out 1: serial line, idle high.
- `busy` out 1: FSM not in IDLE.

## Operation
- Register map:
  - 0 TXDATA (W): pushes `wdata` if FIFO not full. Full ⇒ write dropped, `overflow` set. Reads return 0.
  - 1 STATUS (R): {3'b0, parity_en, overflow, busy, full, empty}. Writing with wdata[3]=1 clears `overflow`.
  - 2 CTRL (R/W): bit0 `tx_enable`. Other bits read 0.
  - 3: reads 0, writes ignored.
- `parity_en` reads 1 only when the parity build is compiled in.
- Full/empty use the FIFO count at the start of the cycle. A push to a full FIFO is dropped even if the FSM pops in the same cycle.
- If an overflow-setting write and an overflow-clearing write coincide, set wins. Both cannot occur in one access, so this only arises through back-to-back scenarios.
- FSM states: IDLE, START, DATA, [PARITY], STOP. Each non-IDLE state drives `tx` for exactly `CLKS_PER_BIT` cycles, timed by a bit counter that runs 0..CLKS_PER_BIT-1.
  - IDLE: `tx`=1. If `tx_enable` and FIFO not empty: pop the head into the shift register → START.
  - START: `tx`=0 → DATA.
  - DATA: `tx`=shift[0], shifting right each bit. After 8 bits → PARITY if compiled in, else STOP.
  - PARITY: `tx`=even parity (XOR of the 8 data bits) → STOP.
  - STOP: `tx`=1. At the end of the bit: if `tx_enable` and not empty, pop → START (no gap). Otherwise → IDLE.
- Clearing `tx_enable` mid-frame does not abort the frame; the current frame completes and no new one starts.
- Reset mid-frame: the frame is abandoned, `tx`=1 the next cycle, and the FIFO is emptied.

## Timing
- Reset values: `tx`=1, `busy`=0, `rdata`=0, `tx_enable`=0, `overflow`=0, FIFO empty, FSM IDLE.
- `rdata` is valid the cycle after `rd_en` and holds until the next read.
- A write at edge N is visible in STATUS from N+1. A CTRL write takes effect at N+1.
- With the FSM idle and enabled, a push at edge N ⇒ pop at N+1 and `tx` falls at N+2. `busy` rises with `tx`.
- Frame length: 10×`CLKS_PER_BIT` clocks (11× with parity). Back-to-back frames have zero idle cycles between them.
- `busy` falls on the cycle the FSM returns to IDLE, exactly `CLKS_PER_BIT` clocks after the stop bit begins.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is present, frames are 11 bits (even parity), and STATUS bit4=1.
- Not defined: the PARITY state is absent, frames are 8N1 (10 bits, matching the receiver), and STATUS bit4=0.

## Test plan
- Reset, set CTRL=1, write 0xA5 (CLKS_PER_BIT=5) → `tx` low 5 clks, then bits 1,0,1,0,0,1,0,1 at 5 clks each, then high 5 clks; `busy` high for 50 clks; loopback receiver reports 0xA5.
- With CTRL=0, write 0x01..0x05 → STATUS reads 0x02 after the 4th write (full), 0x0A after the 5th (overflow); `tx` stays 1. Set CTRL=1 → four gapless frames 0x01..0x04; 0x05 is never sent.
- Write STATUS with wdata=0x08 → overflow reads 0. Push 0x3C in the same cycle the FSM pops from a full FIFO → push dropped, overflow=1.
- Mid-DATA of byte 0x55, write CTRL=0 → frame completes; a queued 0x66 is not sent until CTRL=1.
- Assert `rst` during bit 3 of 0xFF → next cycle `tx`=1, `busy`=0, STATUS=0x01, CTRL reads 0.
- With `UART_TX_PARITY_EN` defined, send 0x07 → parity bit 1, frame 55 clks; send 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_mm_tx.sv
// Memory-mapped UART transmitter: register map, TX FIFO and 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames, STATUS bit4=1).
`timescale 1ns/1ps
module uart_mm_tx #(
   parameter int CLKS_PER_BIT = 5,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       tx,
   output logic       busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_BIT = 1'b1;
`else
   localparam logic PARITY_BIT = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          state;
   logic [CW-1:0]   bit_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
   logic            par;
`endif
   logic            tx_enable;
   logic            overflow;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;

   logic            full;
   logic            empty;
   logic            data_hit;
   logic            push;
   logic            drop;
   logic            bit_end;
   logic            pop;
   logic [7:0]      head;

   // Full/empty come from the count at the start of the cycle, so a push to a
   // full FIFO is dropped even when the serialiser pops on the same edge.
   always_comb begin
      full     = (count == (AW+1)'(FIFO_DEPTH));
      empty    = (count == '0);
      data_hit = wr_en && (addr == 2'd0);
      push     = data_hit && !full;
      drop     = data_hit && full;
      bit_end  = (bit_cnt == CW'(CLKS_PER_BIT - 1));
      pop      = tx_enable && !empty &&
                 ((state == S_IDLE) || ((state == S_STOP) && bit_end));
      head     = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_enable <= 1'b0;
         overflow  <= 1'b0;
         rdata     <= '0;
      end else begin
         if (wr_en && (addr == 2'd2)) tx_enable <= wdata[0];
         if (drop)
            overflow <= 1'b1;
         else if (wr_en && (addr == 2'd1) && wdata[3])
            overflow <= 1'b0;
         if (rd_en) begin
            case (addr)
               2'd1:    rdata <= {3'b000, PARITY_BIT, overflow, busy, full, empty};
               2'd2:    rdata <= {7'b0, tx_enable};
               default: rdata <= '0;
            endcase
         end
      end
   end

   // tx and busy are registered from the current state, so both lag the
   // state register by one clock (pop at N, tx falls at N+1).
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         busy    <= (state != S_IDLE);
         bit_cnt <= ((state == S_IDLE) || bit_end) ? '0 : bit_cnt + CW'(1);
         case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shift <= head;
`ifdef UART_TX_PARITY_EN
                  par   <= ^head;
`endif
                  state <= S_START;
               end
            end
            S_START: begin
               tx <= 1'b0;
               if (bit_end) begin
                  bit_idx <= '0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               tx <= shift[0];
               if (bit_end) begin
                  shift   <= {1'b0, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                  if (bit_idx == 3'd7) state <= S_PARITY;
`else
                  if (bit_idx == 3'd7) state <= S_STOP;
`endif
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               tx <= par;
               if (bit_end) state <= S_STOP;
            end
`endif
            S_STOP: begin
               tx <= 1'b1;
               if (bit_end) begin
                  if (pop) begin
                     shift <= head;
`ifdef UART_TX_PARITY_EN
                     par   <= ^head;
`endif
                     state <= S_START;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mm_tx.sv
// Directed + random bench for uart_mm_tx with a mid-bit sampling loopback receiver.
`timescale 1ns/1ps
module tb_uart_mm_tx;

   localparam int CPB   = 5;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int         NB = 11;
   localparam logic [7:0] PB = 8'h10;
`else
   localparam int         NB = 10;
   localparam logic [7:0] PB = 8'h00;
`endif
   localparam int FRAME = NB * CPB;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      logic [7:0]  data;
      logic        par;
      int unsigned start;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] wdata = 8'd0;
   logic [7:0] rdata;
   logic       tx;
   logic       busy;

   int unsigned cyc = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   frame_t      rxq[$];

   uart_mm_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .tx(tx), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      addr = a; rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      d = rdata;
   endtask

   // Waits (bounded) for the expected frames, then compares data, parity and spacing.
   task automatic check_frames(input byte_q_t exp, input bit gapless);
      int k = 0;
      int budget = exp.size() * FRAME + 200;
      while (rxq.size() < exp.size() && k < budget) begin
         step(1);
         k++;
      end
      chk("rx_count", rxq.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         if (i < rxq.size()) begin
            chk("rx_data", rxq[i].data, exp[i]);
`ifdef UART_TX_PARITY_EN
            chk("rx_parity", rxq[i].par, $countones(exp[i]) % 2);
`endif
            if (gapless && i > 0)
               chk("frame_spacing", rxq[i].start - rxq[i-1].start, FRAME);
         end
      end
      rxq.delete();
   endtask

   // Loopback receiver: samples each bit mid-period, discards frames cut by reset.
   initial begin : monitor
      logic [NB-1:0] bits;
      frame_t        f;
      bit            abort;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            f.start = cyc;
            bits = '0;
            abort = 1'b0;
            for (int j = 1; j < FRAME; j++) begin
               @(negedge clk);
               if (rst) abort = 1'b1;
               if (j % CPB == CPB / 2) bits[j / CPB] = tx;
            end
            if (!abort) begin
               chk("start_bit", bits[0], 1'b0);
               chk("stop_bit", bits[NB-1], 1'b1);
               f.data = bits[8:1];
`ifdef UART_TX_PARITY_EN
               f.par = bits[9];
`else
               f.par = 1'b0;
`endif
               rxq.push_back(f);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin : stim
      logic [7:0]  d;
      logic [NB-1:0] fb;
      logic [7:0]  b;
      byte_q_t     q;
      int          n;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rdata", rdata, 8'h00);
      rst = 1'b0;
      step(1);
      rd(2'd1, d); chk("rst_status", d, 8'h01 | PB);
      rd(2'd2, d); chk("rst_ctrl", d, 8'h00);

      // Single frame 0xA5, cycle-exact waveform
      wr(2'd2, 8'h01);
      b = 8'hA5;
`ifdef UART_TX_PARITY_EN
      fb = {1'b1, ^b, b, 1'b0};
`else
      fb = {1'b1, b, 1'b0};
`endif
      wr(2'd0, b);
      step(1);
      chk("pop_cycle_tx", tx, 1'b1);
      chk("pop_cycle_busy", busy, 1'b0);
      for (int k = 0; k < FRAME; k++) begin
         step(1);
         chk("wave_tx", tx, fb[k / CPB]);
         chk("wave_busy", busy, 1'b1);
      end
      step(1);
      chk("end_tx", tx, 1'b1);
      chk("end_busy", busy, 1'b0);
      check_frames('{8'hA5}, 1'b0);
      rd(2'd1, d); chk("idle_status", d, 8'h01 | PB);

      // Fill while disabled, overflow, clear, push/pop race
      wr(2'd2, 8'h00);
      for (int i = 1; i <= 4; i++) wr(2'd0, 8'(i));
      rd(2'd1, d); chk("status_full", d, 8'h02 | PB);
      wr(2'd0, 8'h05);
      rd(2'd1, d); chk("status_overflow", d, 8'h0A | PB);
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("disabled_tx", tx, 1'b1);
      end
      wr(2'd1, 8'h08);
      rd(2'd1, d); chk("overflow_clear", d, 8'h02 | PB);
      wr(2'd2, 8'h01);
      wr(2'd0, 8'h3C);
      rd(2'd1, d);
      chk("race_overflow", d[3], 1'b1);
      chk("race_not_full", d[1], 1'b0);
      check_frames('{8'h01, 8'h02, 8'h03, 8'h04}, 1'b1);
      step(2 * FRAME);
      chk("no_extra_frames", rxq.size(), 0);
      rd(2'd1, d); chk("drained_status", d, 8'h09 | PB);
      wr(2'd1, 8'h08);

      // Disable mid-DATA: frame completes, queued byte held
      wr(2'd0, 8'h55);
      wr(2'd0, 8'h66);
      step(15);
      wr(2'd2, 8'h00);
      check_frames('{8'h55}, 1'b0);
      step(2 * FRAME);
      chk("held_no_frame", rxq.size(), 0);
      rd(2'd1, d); chk("held_status", d, 8'h00 | PB);
      wr(2'd2, 8'h01);
      check_frames('{8'h66}, 1'b0);

      // Reset during data bit 3 of 0xFF
      wr(2'd0, 8'hFF);
      wr(2'd0, 8'h11);
      step(21);
      rst = 1'b1;
      step(1);
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_rdata", rdata, 8'h00);
      rst = 1'b0;
      rd(2'd1, d); chk("midrst_status", d, 8'h01 | PB);
      rd(2'd2, d); chk("midrst_ctrl", d, 8'h00);
      wr(2'd2, 8'h01);
      step(2 * FRAME);
      chk("midrst_flushed", rxq.size(), 0);
      rxq.delete();

      // Parity-sensitive pair, back to back
      wr(2'd0, 8'h07);
      wr(2'd0, 8'h03);
      check_frames('{8'h07, 8'h03}, 1'b1);

      // Random bursts (never overfill) must arrive gapless and in order
      for (int r = 0; r < 6; r++) begin
         q.delete();
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            wr(2'd0, b);
         end
         check_frames(q, 1'b1);
      end

      // Random trickle with random gaps
      q.delete();
      for (int i = 0; i < 4; i++) begin
         step($urandom_range(0, 80));
         b = 8'($urandom);
         q.push_back(b);
         wr(2'd0, b);
      end
      check_frames(q, 1'b0);
      rd(2'd1, d); chk("final_overflow", d[3], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
